// File: rtl/mc_cu.sv
// mc_cu: multicycle RISC-V control unit with branch decode, illegal-op trap
// and a retired-instruction counter.
module mc_cu #(
  parameter int ALUCTRL_W     = 3,
  parameter bit EN_BRANCH_EXT = 1'b1,
  parameter int CNT_W         = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [6:0]           op,
  input  logic [2:0]           funct3,
  input  logic                 funct7b5,
  input  logic                 Zero,
  input  logic                 Neg,
  output logic                 PCWrite,
  output logic                 IRWrite,
  output logic                 MemWrite,
  output logic                 RegWrite,
  output logic                 AdrSrc,
  output logic [1:0]           ResultSrc,
  output logic [1:0]           ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic [1:0]           ImmSrc,
  output logic [ALUCTRL_W-1:0] ALUControl,
  output logic [3:0]           state,
  output logic                 done,
  output logic                 illegal,
  output logic [CNT_W-1:0]     retired
);
  typedef enum logic [3:0] {
    FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMREAD = 4'd3,
    MEMWB = 4'd4, MEMWRITE = 4'd5, EXECR = 4'd6, ALUWB = 4'd7,
    EXECI = 4'd8, JAL = 4'd9, BRANCH = 4'd10, TRAP = 4'd11
  } state_t;
  localparam logic [6:0] OP_LW = 7'b0000011, OP_SW = 7'b0100011, OP_R = 7'b0110011,
                         OP_I = 7'b0010011, OP_JAL = 7'b1101111, OP_BR = 7'b1100011;
  state_t r_state, w_next, w_st;
  logic [CNT_W-1:0] r_retired;
  logic w_pcw, w_irw, w_mw, w_rw, w_taken;
  logic [2:0] w_alu, w_alu_dec;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= FETCH;
      r_retired <= '0;
    end else begin
      r_state <= w_next;
      if (done) r_retired <= r_retired + CNT_W'(1);
    end
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      FETCH:   w_next = DECODE;
      DECODE:
        case (op)
          OP_LW, OP_SW: w_next = MEMADR;
          OP_R:         w_next = EXECR;
          OP_I:         w_next = EXECI;
          OP_JAL:       w_next = JAL;
          OP_BR:        w_next = BRANCH;
          default:      w_next = TRAP;
        endcase
      MEMADR:  w_next = (op == OP_SW) ? MEMWRITE : MEMREAD;
      MEMREAD: w_next = MEMWB;
      EXECR, EXECI, JAL: w_next = ALUWB;
      MEMWB, MEMWRITE, ALUWB, BRANCH: w_next = FETCH;
      default: w_next = TRAP;
    endcase
  end
  assign w_alu_dec = (funct3 == 3'b010) ? 3'b101 :
                     (funct3 == 3'b110) ? 3'b011 :
                     (funct3 == 3'b111) ? 3'b010 :
                     (funct3 == 3'b000 && op == OP_R && funct7b5) ? 3'b001 : 3'b000;
  assign w_taken = (funct3 == 3'b000) ? Zero :
                   !EN_BRANCH_EXT     ? 1'b0 :
                   (funct3 == 3'b001) ? !Zero :
                   (funct3 == 3'b100) ? Neg :
                   (funct3 == 3'b101) ? !Neg : 1'b0;
  // While in reset the muxes show FETCH values; enables are masked below.
  assign w_st = rst_n ? r_state : FETCH;
  always_comb begin
    w_pcw     = 1'b0;
    w_irw     = 1'b0;
    w_mw      = 1'b0;
    w_rw      = 1'b0;
    AdrSrc    = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    w_alu     = 3'b000;
    case (w_st)
      FETCH:    begin w_irw = 1'b1; w_pcw = 1'b1; ALUSrcB = 2'b10; ResultSrc = 2'b10; end
      DECODE:   begin ALUSrcA = 2'b01; ALUSrcB = 2'b01; end
      MEMADR:   begin ALUSrcA = 2'b10; ALUSrcB = 2'b01; end
      MEMREAD:  AdrSrc = 1'b1;
      MEMWRITE: begin AdrSrc = 1'b1; w_mw = 1'b1; end
      MEMWB:    begin ResultSrc = 2'b01; w_rw = 1'b1; end
      EXECR:    begin ALUSrcA = 2'b10; w_alu = w_alu_dec; end
      EXECI:    begin ALUSrcA = 2'b10; ALUSrcB = 2'b01; w_alu = w_alu_dec; end
      JAL:      begin ALUSrcA = 2'b01; ALUSrcB = 2'b10; w_pcw = 1'b1; end
      ALUWB:    w_rw = 1'b1;
      BRANCH:   begin ALUSrcA = 2'b10; w_alu = 3'b001; w_pcw = w_taken; end
      default:  ;
    endcase
  end
  assign ImmSrc     = (op == OP_SW) ? 2'b01 : (op == OP_BR) ? 2'b10 : (op == OP_JAL) ? 2'b11 : 2'b00;
  assign ALUControl = ALUCTRL_W'(w_alu);
  assign PCWrite    = rst_n & w_pcw;
  assign IRWrite    = rst_n & w_irw;
  assign MemWrite   = rst_n & w_mw;
  assign RegWrite   = rst_n & w_rw;
  assign done       = rst_n & (r_state == MEMWB || r_state == MEMWRITE || r_state == ALUWB || r_state == BRANCH);
  assign illegal    = rst_n & (r_state == TRAP);
  assign state      = r_state;
  assign retired    = r_retired;
endmodule

// File: tb/tb_mc_cu.sv
// tb_mc_cu: table-driven and randomized checks of mc_cu against a per-instruction
// reference model; a second instance covers the no-branch-ext / 4-bit-counter build.
module tb_mc_cu;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [6:0] op = '0;
  logic [2:0] funct3 = '0;
  logic funct7b5 = 1'b0, Zero = 1'b0, Neg = 1'b0;
  logic pcw_a, irw_a, mw_a, rw_a, adr_a, done_a, ill_a;
  logic [1:0] rs_a, sa_a, sb_a, imm_a;
  logic [2:0] alu_a;
  logic [3:0] st_a;
  logic [31:0] ret_a;
  logic pcw_b, irw_b, mw_b, rw_b, adr_b, done_b, ill_b;
  logic [1:0] rs_b, sa_b, sb_b, imm_b;
  logic [3:0] alu_b, st_b, ret_b;
  logic [22:0] act_a, act_b;
  int checks = 0, errors = 0, ret_m = 0;
  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011,
                         IT = 7'b0010011, JL = 7'b1101111, BR = 7'b1100011;

  always #5 clk = ~clk;

  mc_cu dut_a (
    .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7b5(funct7b5), .Zero(Zero), .Neg(Neg),
    .PCWrite(pcw_a), .IRWrite(irw_a), .MemWrite(mw_a), .RegWrite(rw_a), .AdrSrc(adr_a),
    .ResultSrc(rs_a), .ALUSrcA(sa_a), .ALUSrcB(sb_a), .ImmSrc(imm_a), .ALUControl(alu_a),
    .state(st_a), .done(done_a), .illegal(ill_a), .retired(ret_a)
  );
  mc_cu #(.ALUCTRL_W(4), .EN_BRANCH_EXT(1'b0), .CNT_W(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7b5(funct7b5), .Zero(Zero), .Neg(Neg),
    .PCWrite(pcw_b), .IRWrite(irw_b), .MemWrite(mw_b), .RegWrite(rw_b), .AdrSrc(adr_b),
    .ResultSrc(rs_b), .ALUSrcA(sa_b), .ALUSrcB(sb_b), .ImmSrc(imm_b), .ALUControl(alu_b),
    .state(st_b), .done(done_b), .illegal(ill_b), .retired(ret_b)
  );

  assign act_a = {st_a, pcw_a, irw_a, mw_a, rw_a, adr_a, rs_a, sa_a, sb_a, imm_a, 1'b0, alu_a, done_a, ill_a};
  assign act_b = {st_b, pcw_b, irw_b, mw_b, rw_b, adr_b, rs_b, sa_b, sb_b, imm_b, alu_b, done_b, ill_b};

  function automatic logic [3:0] alu_ref();
    logic [2:0] by_f3 [8];
    by_f3 = '{3'd0, 3'd0, 3'd5, 3'd0, 3'd0, 3'd0, 3'd3, 3'd2};
    if (funct3 == 3'b000 && op == RT && funct7b5) return 4'd1;
    return {1'b0, by_f3[funct3]};
  endfunction

  function automatic logic taken_ref(bit ext);
    case (funct3)
      3'b000:  return Zero;
      3'b001:  return ext & !Zero;
      3'b100:  return ext & Neg;
      3'b101:  return ext & !Neg;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [22:0] exp_out(int s, bit ext, bit in_rst);
    logic pcw, irw, mw, rw, adr;
    logic [1:0] rs, sa, sb, imm;
    logic [3:0] alu;
    {pcw, irw, mw, rw, adr, rs, sa, sb, alu} = '0;
    case (in_rst ? 0 : s)
      0:  begin pcw = 1; irw = 1; sb = 2; rs = 2; end
      1:  begin sa = 1; sb = 1; end
      2:  begin sa = 2; sb = 1; end
      3:  adr = 1;
      4:  begin rs = 1; rw = 1; end
      5:  begin adr = 1; mw = 1; end
      6:  begin sa = 2; alu = alu_ref(); end
      7:  rw = 1;
      8:  begin sa = 2; sb = 1; alu = alu_ref(); end
      9:  begin sa = 1; sb = 2; pcw = 1; end
      10: begin sa = 2; alu = 4'd1; pcw = taken_ref(ext); end
      default: ;
    endcase
    imm = (op == SW) ? 2'd1 : (op == BR) ? 2'd2 : (op == JL) ? 2'd3 : 2'd0;
    if (in_rst) {pcw, irw, mw, rw} = '0;
    return {4'(s), pcw, irw, mw, rw, adr, rs, sa, sb, imm, alu,
            !in_rst && (s == 4 || s == 5 || s == 7 || s == 10), !in_rst && s == 11};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic check_cycle(input int s, input bit in_rst);
    chk("outs_a", 32'(act_a), 32'(exp_out(s, 1'b1, in_rst)));
    chk("outs_b", 32'(act_b), 32'(exp_out(s, 1'b0, in_rst)));
    chk("retired_a", ret_a, 32'(ret_m));
    chk("retired_b", 32'(ret_b), 32'(ret_m % 16));
  endtask

  task automatic do_reset(input int cur);
    rst_n = 1'b0;
    #1 check_cycle(cur, 1'b1);
    @(posedge clk); #1;
    ret_m = 0;
    check_cycle(0, 1'b1);
    rst_n = 1'b1;
    #1;
  endtask

  // Runs one instruction from FETCH, checking every cycle against the model.
  task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7, z, n,
                           input int abort_at, output int len, output logic [3:0] alu_x,
                           output logic pcw_last_a, output logic pcw_last_b);
    int path[$];
    op = o; funct3 = f3; funct7b5 = f7; Zero = z; Neg = n;
    #1;
    case (o)
      LW: path = '{0, 1, 2, 3, 4};
      SW: path = '{0, 1, 2, 5};
      RT: path = '{0, 1, 6, 7};
      IT: path = '{0, 1, 8, 7};
      JL: path = '{0, 1, 9, 7};
      BR: path = '{0, 1, 10};
      default: begin path = '{0, 1}; repeat (10) path.push_back(11); end
    endcase
    len = 0; alu_x = '0; pcw_last_a = 1'b0; pcw_last_b = 1'b0;
    foreach (path[k]) begin
      if (k == abort_at) begin
        do_reset(path[k]);
        return;
      end
      check_cycle(path[k], 1'b0);
      if (len == 0 && done_a) len = k + 1;
      if (path[k] == 6 || path[k] == 8 || path[k] == 10) alu_x = {1'b0, alu_a};
      pcw_last_a = pcw_a;
      pcw_last_b = pcw_b;
      @(posedge clk); #1;
      if (path[k] inside {4, 5, 7, 10}) ret_m++;
    end
    if (path[path.size()-1] == 11) do_reset(11);
  endtask

  typedef struct {
    logic [6:0] op; logic [2:0] f3; logic f7, z, n;
    int len; logic [3:0] alu; logic pcw_a, pcw_b;
  } vec_t;
  vec_t tbl [18];

  initial begin
    int len;
    logic [3:0] alu_x;
    logic pa, pb;
    logic [6:0] ops [8];
    tbl[0]  = '{LW, 3'b010, 1'b0, 1'b0, 1'b0, 5, 4'd0, 1'b0, 1'b0};
    tbl[1]  = '{SW, 3'b010, 1'b0, 1'b0, 1'b0, 4, 4'd0, 1'b0, 1'b0};
    tbl[2]  = '{RT, 3'b000, 1'b1, 1'b0, 1'b0, 4, 4'd1, 1'b0, 1'b0};
    tbl[3]  = '{RT, 3'b000, 1'b0, 1'b0, 1'b0, 4, 4'd0, 1'b0, 1'b0};
    tbl[4]  = '{IT, 3'b000, 1'b1, 1'b0, 1'b0, 4, 4'd0, 1'b0, 1'b0};
    tbl[5]  = '{RT, 3'b010, 1'b0, 1'b0, 1'b0, 4, 4'd5, 1'b0, 1'b0};
    tbl[6]  = '{IT, 3'b110, 1'b0, 1'b0, 1'b0, 4, 4'd3, 1'b0, 1'b0};
    tbl[7]  = '{RT, 3'b111, 1'b1, 1'b0, 1'b0, 4, 4'd2, 1'b0, 1'b0};
    tbl[8]  = '{RT, 3'b001, 1'b1, 1'b0, 1'b0, 4, 4'd0, 1'b0, 1'b0};
    tbl[9]  = '{JL, 3'b000, 1'b0, 1'b0, 1'b0, 4, 4'd0, 1'b0, 1'b0};
    tbl[10] = '{BR, 3'b000, 1'b0, 1'b1, 1'b0, 3, 4'd1, 1'b1, 1'b1};
    tbl[11] = '{BR, 3'b000, 1'b0, 1'b0, 1'b0, 3, 4'd1, 1'b0, 1'b0};
    tbl[12] = '{BR, 3'b001, 1'b0, 1'b0, 1'b0, 3, 4'd1, 1'b1, 1'b0};
    tbl[13] = '{BR, 3'b100, 1'b0, 1'b0, 1'b1, 3, 4'd1, 1'b1, 1'b0};
    tbl[14] = '{BR, 3'b101, 1'b0, 1'b0, 1'b0, 3, 4'd1, 1'b1, 1'b0};
    tbl[15] = '{BR, 3'b101, 1'b0, 1'b0, 1'b1, 3, 4'd1, 1'b0, 1'b0};
    tbl[16] = '{BR, 3'b010, 1'b0, 1'b1, 1'b1, 3, 4'd1, 1'b0, 1'b0};
    tbl[17] = '{BR, 3'b001, 1'b0, 1'b1, 1'b0, 3, 4'd1, 1'b0, 1'b0};
    ops = '{LW, SW, RT, IT, JL, BR, 7'b1111111, 7'b0000000};
    repeat (2) @(posedge clk);
    #1 check_cycle(0, 1'b1);
    rst_n = 1'b1;
    #1;
    foreach (tbl[i]) begin
      run_instr(tbl[i].op, tbl[i].f3, tbl[i].f7, tbl[i].z, tbl[i].n, -1, len, alu_x, pa, pb);
      chk($sformatf("len[%0d]", i), 32'(len), 32'(tbl[i].len));
      chk($sformatf("alu[%0d]", i), 32'(alu_x), 32'(tbl[i].alu));
      chk($sformatf("pcw_a[%0d]", i), 32'(pa), 32'(tbl[i].pcw_a));
      chk($sformatf("pcw_b[%0d]", i), 32'(pb), 32'(tbl[i].pcw_b));
    end
    run_instr(7'b1111111, 3'b000, 1'b0, 1'b0, 1'b0, -1, len, alu_x, pa, pb);
    run_instr(JL, 3'b000, 1'b0, 1'b0, 1'b0, -1, len, alu_x, pa, pb);
    run_instr(LW, 3'b010, 1'b0, 1'b0, 1'b0, 3, len, alu_x, pa, pb);
    repeat (15) run_instr(BR, 3'b000, 1'b0, 1'b1, 1'b0, -1, len, alu_x, pa, pb);
    chk("ret_b_15", 32'(ret_b), 32'd15);
    run_instr(BR, 3'b000, 1'b0, 1'b0, 1'b0, -1, len, alu_x, pa, pb);
    chk("ret_b_wrap", 32'(ret_b), 32'd0);
    chk("ret_a_16", ret_a, 32'd16);
    repeat (60) begin
      logic [6:0] o;
      o = ($urandom_range(0, 9) == 0) ? 7'($urandom) : ops[$urandom_range(0, 7)];
      run_instr(o, 3'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), -1, len, alu_x, pa, pb);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mc_cu.md
MC_CU -- requirements
Module: mc_cu

Interface
REQ-001 Parameter ALUCTRL_W, default 3: ALUControl width; SHALL be at least 3; bits above [2:0] SHALL be driven 0.
REQ-002 Parameter EN_BRANCH_EXT, default 1: when 1, bne/blt/bge are decoded; when 0, only beq is decoded.
REQ-003 Parameter CNT_W, default 32: width of the retired-instruction counter.
REQ-004 clk input 1: single clock; all state updates on its rising edge.
REQ-005 rst_n input 1: reset, synchronous and active-low.
REQ-006 op, funct3, funct7b5 inputs, 7/3/1 bits: fields of the latched instruction register.
REQ-007 Zero, Neg inputs, 1 bit each: ALU flags; Zero means result==0, Neg means signed A<B.
REQ-008 PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc outputs, 1 bit each: datapath enables/select.
REQ-009 ResultSrc, ALUSrcA, ALUSrcB, ImmSrc outputs, 2 bits each: datapath muxes.
REQ-010 ALUControl output, ALUCTRL_W bits: ALU operation.
REQ-011 state output 4 bits (debug), done output 1 bit (last cycle of an instruction), illegal output 1 bit (trap), retired output CNT_W bits (instruction count).

Function
REQ-012 The FSM SHALL use encodings FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, ALUWB=7, EXECI=8, JAL=9, BRANCH=10, TRAP=11.
REQ-013 Transitions SHALL be:
- FETCH->DECODE.
- DECODE by op: lw 0000011 or sw 0100011 -> MEMADR; R 0110011 -> EXECR; I 0010011 -> EXECI; jal 1101111 -> JAL; branch 1100011 -> BRANCH; any other op -> TRAP.
- MEMADR -> MEMREAD (lw) or MEMWRITE (sw); MEMREAD -> MEMWB.
- EXECR, EXECI and JAL -> ALUWB.
- MEMWB, MEMWRITE, ALUWB and BRANCH -> FETCH.
- TRAP -> TRAP until reset.
REQ-014 Per-state outputs SHALL be as below; every signal not listed is 0.
- FETCH: IRWrite=1, PCWrite=1, ALUSrcA=00, ALUSrcB=10, ResultSrc=10, ALUControl=add.
- DECODE: ALUSrcA=01, ALUSrcB=01, add.
- MEMADR: ALUSrcA=10, ALUSrcB=01, add.
- MEMREAD: AdrSrc=1.
- MEMWRITE: AdrSrc=1, MemWrite=1.
- MEMWB: ResultSrc=01, RegWrite=1.
- EXECR: ALUSrcA=10, ALUSrcB=00, R-decode.
- EXECI: ALUSrcA=10, ALUSrcB=01, I-decode.
- JAL: ALUSrcA=01, ALUSrcB=10, add, PCWrite=1.
- ALUWB: RegWrite=1.
- BRANCH: ALUSrcA=10, ALUSrcB=00, sub, PCWrite=taken.
REQ-015 ImmSrc SHALL be a function of op only: lw/I -> 00, sw -> 01, branch -> 10, jal -> 11; any other op -> 00.
REQ-016 ALUControl encodings SHALL be add=000, sub=001, and=010, or=011, slt=101.
REQ-017 Decode by funct3:
- 000: sub when R-type and funct7b5=1, otherwise add; addi SHALL ignore funct7b5.
- 010 -> slt; 110 -> or; 111 -> and; any other funct3 -> add.
REQ-018 Branch taken rules by funct3: 000 -> Zero; 001 -> !Zero; 100 -> Neg; 101 -> !Neg.
- When EN_BRANCH_EXT=0, only 000 can be taken.
- All other funct3 values -> not taken, and the branch still completes in 3 cycles.
REQ-019 Latency in cycles, FETCH included: lw 5; sw, R, I and jal 4; branch 3.
REQ-020 done SHALL be 1 in MEMWB, MEMWRITE, ALUWB and BRANCH, and 0 otherwise.
REQ-021 retired SHALL increment by 1 on each clock edge where done=1, and SHALL wrap from all-ones to 0.
REQ-022 illegal SHALL be 1 in TRAP; in TRAP all write enables SHALL be 0 and retired SHALL hold.
REQ-023 state output SHALL equal the current FSM state register.

Reset
REQ-024 A clock edge with rst_n=0 SHALL set state=FETCH and retired=0; this SHALL apply from any state, including mid-instruction and TRAP.
REQ-025 While rst_n=0, PCWrite, IRWrite, MemWrite, RegWrite, done and illegal SHALL be forced to 0 combinationally; all other outputs take their FETCH values.
REQ-026 The first clock edge with rst_n=1 SHALL perform a normal FETCH->DECODE transition.

Verification
REQ-027 lw (op 0000011): states 0,1,2,3,4. RegWrite=1 only in cycle 5, with ResultSrc=01. retired increments 0->1.
REQ-028 sw (op 0100011, funct3 010): states 0,1,2,5. MemWrite=1 and AdrSrc=1 in cycle 4 only. ImmSrc=01 throughout.
REQ-029 R-type (op 0110011, funct3 000):
- funct7b5=1: ALUControl=001 in EXECR.
- funct7b5=0: ALUControl=000.
- addi (op 0010011) with funct7b5=1: ALUControl=000.
REQ-030 Branch cases, PCWrite in BRANCH:
- beq with Zero=1 -> 1; with Zero=0 -> 0.
- bne with Zero=0 -> 1.
- blt with Neg=1 -> 1.
- EN_BRANCH_EXT=0 build, bne with Zero=0 -> 0.
REQ-031 Illegal op 1111111:
- After DECODE, state=11 and illegal=1 for 10 or more cycles, with all enables 0 and retired unchanged.
- rst_n=0 for one edge gives state=0 and illegal=0.
REQ-032 Reset mid-lw in MEMREAD (state 3): the next edge gives state 0 and retired=0, and RegWrite never pulses. Also with CNT_W=4, 16 retired instructions wrap retired 15->0.
